// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bus for hazard_stall_ctrl.
// master: the pipeline side (drives hazard sources, receives stall/flush).
// slave : the hazard/stall controller itself.
interface hazard_stall_ctrl_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic        Rs1UsedD;
  logic        Rs2UsedD;
  logic [4:0]  RdE;
  logic        MemReadE;
  logic        PCSrcE;
  logic        MduReqE;
  logic        MduDone;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        FlushD;
  logic        FlushE;
  logic        FlushM;
  logic        MduTimeout;
  logic [31:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, RdE, MemReadE, PCSrcE, MduReqE, MduDone,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, MduTimeout, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1UsedD, Rs2UsedD, RdE, MemReadE, PCSrcE, MduReqE, MduDone,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, MduTimeout, StallCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage RV32 core.
// Handles load-use hazards, EX redirects and multi-cycle MDU occupancy,
// with a watchdog that force-releases a hung MDU operation.
// Optional macro STALL_PERF_CNT_EN enables the saturating StallCount
// perf counter; when undefined StallCount is tied to zero.
module hazard_stall_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;

  logic mdu_hold_s;
  logic lu_s;
  logic stall_f_s;
  logic stall_d_s;
  logic stall_e_s;
  logic flush_d_s;
  logic flush_e_s;
  logic flush_m_s;

  // Hazard detection and prioritised stall/flush decode (zero-cycle latency).
  always_comb begin
    mdu_hold_s = bus.MduReqE && !bus.MduDone &&
                 ((state_r == MDU_WAIT) || ((state_r == RUN) && !bus.PCSrcE));
    lu_s       = bus.MemReadE && (bus.RdE != 5'd0) &&
                 ((bus.Rs1UsedD && (bus.RdE == bus.Rs1D)) ||
                  (bus.Rs2UsedD && (bus.RdE == bus.Rs2D)));
    stall_f_s  = 1'b0;
    stall_d_s  = 1'b0;
    stall_e_s  = 1'b0;
    flush_d_s  = 1'b0;
    flush_e_s  = 1'b0;
    flush_m_s  = 1'b0;
    if (reset) begin
      // All controls released while reset is asserted.
      stall_f_s = 1'b0;
    end else if (mdu_hold_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      flush_m_s = 1'b1;
    end else if ((state_r == RUN) && bus.PCSrcE) begin
      // Redirect wins over load-use: the dependent instruction is discarded anyway.
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if ((state_r == RUN) && lu_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_f_s = 1'b0;
    end
  end

  // MDU sequencing FSM with watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= RUN;
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (mdu_hold_s) begin
            state_r <= MDU_WAIT;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= RUN;
          end
        end
        MDU_WAIT: begin
          if (bus.MduDone) begin
            // Stalls are already low this cycle, so the op retires on this edge.
            state_r <= RUN;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r   <= RUN;
            cnt_r     <= '0;
            timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_count_r;

  // Saturating count of cycles in which the front end was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_r <= 32'd0;
    end else if (stall_f_s && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign bus.StallCount = stall_count_r;
`else
  assign bus.StallCount = 32'd0;
`endif

  assign bus.StallF     = stall_f_s;
  assign bus.StallD     = stall_d_s;
  assign bus.StallE     = stall_e_s;
  assign bus.FlushD     = flush_d_s;
  assign bus.FlushE     = flush_e_s;
  assign bus.FlushM     = flush_m_s;
  assign bus.MduTimeout = timeout_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MDU_TIMEOUT=8).
// Stimulus computes the expected outputs from a behavioural model and
// queues them; a monitor pops and compares on the falling edge.
module tb_hazard_stall_ctrl;

  localparam int TMO = 8;

  logic clk;
  logic reset;

  hazard_stall_ctrl_if bus_if ();

  hazard_stall_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sf;
    logic        sd;
    logic        se;
    logic        fd;
    logic        fe;
    logic        fm;
    logic        tmo;
    logic [31:0] cnt;
    logic [15:0] id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  // Behavioural model state.
  bit      m_busy;     // an MDU op is being waited on
  int      m_waited;   // cycles already stalled for it
  bit      m_tmo;
  longint  m_cnt;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step=%0d actual=%0h expected=%0h", name, id, act, exp);
  endtask

  task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] rde, input bit mr,
                      input bit pc, input bit req, input bit done);
    exp_t e;
    bit   hold;
    bit   lu;
    @(posedge clk);
    #1;
    reset            = rst;
    bus_if.Rs1D      = rs1;
    bus_if.Rs2D      = rs2;
    bus_if.Rs1UsedD  = u1;
    bus_if.Rs2UsedD  = u2;
    bus_if.RdE       = rde;
    bus_if.MemReadE  = mr;
    bus_if.PCSrcE    = pc;
    bus_if.MduReqE   = req;
    bus_if.MduDone   = done;

    e    = '0;
    hold = req && !done && (m_busy || !pc);
    lu   = mr && (rde != 5'd0) && ((u1 && rde == rs1) || (u2 && rde == rs2));
    if (rst) begin
      m_busy = 0; m_waited = 0; m_tmo = 0; m_cnt = 0;
    end else if (hold) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
    end else if (!m_busy && pc) begin
      e.fd = 1; e.fe = 1;
    end else if (!m_busy && lu) begin
      e.sf = 1; e.sd = 1; e.fe = 1;
    end
    e.tmo = m_tmo;
`ifdef STALL_PERF_CNT_EN
    e.cnt = m_cnt[31:0];
`else
    e.cnt = 32'd0;
`endif
    e.id = step_id[15:0];
    step_id++;
    q.push_back(e);

    // Advance the model to the state seen after the coming edge.
    if (!rst) begin
      if (e.sf && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!m_busy) begin
        if (hold) begin m_busy = 1; m_waited = 1; end
      end else if (done) begin
        m_busy = 0;
      end else if (m_waited == TMO - 1) begin
        m_busy = 0; m_tmo = 1;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mdu(input bit done);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, done);
  endtask

  task automatic load_use();
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented output set against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("StallF",     e.id, {31'd0, bus_if.StallF},     {31'd0, e.sf});
      check("StallD",     e.id, {31'd0, bus_if.StallD},     {31'd0, e.sd});
      check("StallE",     e.id, {31'd0, bus_if.StallE},     {31'd0, e.se});
      check("FlushD",     e.id, {31'd0, bus_if.FlushD},     {31'd0, e.fd});
      check("FlushE",     e.id, {31'd0, bus_if.FlushE},     {31'd0, e.fe});
      check("FlushM",     e.id, {31'd0, bus_if.FlushM},     {31'd0, e.fm});
      check("MduTimeout", e.id, {31'd0, bus_if.MduTimeout}, {31'd0, e.tmo});
      check("StallCount", e.id, bus_if.StallCount,          e.cnt);
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    bus_if.Rs1D = 5'd0; bus_if.Rs2D = 5'd0; bus_if.Rs1UsedD = 1'b0; bus_if.Rs2UsedD = 1'b0;
    bus_if.RdE = 5'd0; bus_if.MemReadE = 1'b0; bus_if.PCSrcE = 1'b0;
    bus_if.MduReqE = 1'b0; bus_if.MduDone = 1'b0;
    m_busy = 0; m_waited = 0; m_tmo = 0; m_cnt = 0;

    // Reset state.
    do_reset(); do_reset();
    idle();

    // Load-use: one bubble, then clear once the load leaves EX.
    load_use(); idle();
    // Load-use through Rs2.
    step(1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    // Matching register but source not used: no stall.
    step(1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    // Redirect together with load-use: redirect wins.
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    // RdE==0 with matching sources: never a stall.
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // MDU op finishing on its 4th cycle.
    mdu(1'b0); mdu(1'b0); mdu(1'b0); mdu(1'b1); idle();
    // Single-cycle MDU op.
    mdu(1'b1); idle();
    // MDU request alongside a redirect in RUN: redirect, no MDU hold.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Watchdog: done never comes; 8 stall cycles, then sticky timeout.
    for (int i = 0; i < TMO; i++) mdu(1'b0);
    idle(); idle(); load_use(); idle();

    // Reset in the middle of an MDU wait.
    mdu(1'b0); mdu(1'b0); mdu(1'b0);
    do_reset(); idle();

    // Perf scenario: 3 load-use stalls and a 5-cycle MDU stall.
    load_use(); idle(); load_use(); idle(); load_use(); idle();
    for (int i = 0; i < 5; i++) mdu(1'b0);
    mdu(1'b1); idle(); idle();
    do_reset(); idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0));
    end
    idle();

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d expected=0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline-control block for the 5-stage RV32 integer core. It detects load-use hazards, control redirects from EX, and multi-cycle mul/div occupancy in EX. It drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers. A small FSM sequences multi-cycle MDU operations, with a timeout watchdog.

Parameters:
MDU_TIMEOUT, 64, max cycles spent in MDU_WAIT before forced release (≥2)
CNT_W, 7, width of the watchdog counter (must hold MDU_TIMEOUT)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
Rs1D  in  5  ID-stage source register 1
Rs2D  in  5  ID-stage source register 2
Rs1UsedD  in  1  ID instruction reads Rs1
Rs2UsedD  in  1  ID instruction reads Rs2
RdE  in  5  EX-stage destination register
MemReadE  in  1  EX instruction is a load
PCSrcE  in  1  taken branch/jal/jalr resolved in EX
MduReqE  in  1  EX instruction is mul/div; held while ID/EX is stalled
MduDone  in  1  MDU result valid this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX (its Stall input)
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX (its flush input)
FlushM  out  1  insert bubble into EX/MEM
MduTimeout  out  1  sticky watchdog flag
StallCount  out  32  stall-cycle perf counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, port reset.
- Reset values: state=RUN, watchdog cnt=0, MduTimeout=0, StallCount=0. All stall/flush outputs are 0 while reset is high.
- FSM states: RUN, MDU_WAIT. State, cnt and flags are registered. Stall/flush outputs are combinational from state and inputs, with zero-cycle latency.
- mdu_hold = MduReqE && !MduDone && (state==MDU_WAIT || (state==RUN && !PCSrcE)).
- lu = MemReadE && RdE!=0 && ((Rs1UsedD && RdE==Rs1D) || (Rs2UsedD && RdE==Rs2D)).
- Output priority, first match wins:
  1. mdu_hold: StallF=StallD=StallE=1, FlushM=1, all other outputs 0.
  2. PCSrcE in RUN: FlushD=FlushE=1, stalls 0. Redirect beats load-use.
  3. lu in RUN: StallF=StallD=1, FlushE=1 (one bubble).
  4. Otherwise all outputs 0.
- Transitions:
  - RUN→MDU_WAIT when mdu_hold; cnt←1.
  - MDU_WAIT→RUN when MduDone. Stalls are already 0 in the MduDone cycle, so the MDU instruction advances on that edge.
  - MDU_WAIT→RUN when cnt==MDU_TIMEOUT−1 && !MduDone; MduTimeout←1. Stalls drop on the following cycle.
  - Otherwise in MDU_WAIT: cnt←cnt+1.
- MduReqE && MduDone in the same RUN cycle (1-cycle op): no stall, stay in RUN.
- In MDU_WAIT, PCSrcE and lu are ignored; the MDU op occupies EX.
- MduTimeout is sticky and cleared only by reset.
- Reset asserted mid-MDU_WAIT: immediate return to RUN, cnt=0, stalls released asynchronously.
- RdE==0 never causes a load-use stall.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: StallCount increments on every rising edge where StallF==1. It saturates at 32'hFFFFFFFF and resets to 0.
- Undefined: StallCount is tied to 32'd0 and no counter flops are synthesized. The port is always present.

Test Plan:
- Load-use: MemReadE=1, RdE=5, Rs1D=5, Rs1UsedD=1 → exactly 1 cycle of StallF=StallD=FlushE=1. The next cycle is all 0 (the load has left EX).
- Redirect plus load-use in the same cycle: PCSrcE=1, lu=1 → FlushD=FlushE=1, StallF=0. Also check RdE=0 with matching Rs → no stall.
- MDU op, done on the 4th cycle: MduReqE=1, MduDone low for 3 cycles then high → StallE/FlushM high 3 cycles, 0 in the done cycle, state back to RUN.
- Single-cycle MDU: MduReqE=MduDone=1 in RUN → no stall, state stays RUN.
- Watchdog: MDU_TIMEOUT=8, MduDone never asserted → stalls high 8 cycles, then MduTimeout=1 and RUN. MduTimeout stays 1 until reset.
- Reset mid-MDU_WAIT, then with STALL_PERF_CNT_EN defined: 3 load-use stalls plus one 5-cycle MDU stall → StallCount=3+5=8. Reset → all outputs 0 and StallCount=0.
